// File: rtl/mod_up_down_counter.sv
// Parametrised up/down counter over 0..MAX with step, parallel load, wrap or
// saturate mode, boundary flags, terminal-count pulse and sticky overflow.
module mod_up_down_counter #(
  parameter int unsigned BITS     = 4,
  parameter int unsigned MAX      = 15,
  parameter bit          SATURATE = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            up,
  input  logic [BITS-1:0] step,
  input  logic            load,
  input  logic [BITS-1:0] d,
  input  logic            clr_flags,
  output logic [BITS-1:0] Q,
  output logic            at_max,
  output logic            at_min,
  output logic            tc,
  output logic            ovf
);

  localparam int unsigned W     = BITS + 1;
  localparam bit          FULL  = (MAX == (2 ** BITS) - 1);
  localparam logic [BITS-1:0] MAX_B = BITS'(MAX);
  localparam logic [W-1:0]    MAX_W = W'(MAX);
  localparam logic [W-1:0]    MOD_W = W'(MAX + 1);

  generate
    if (MAX < 1 || (MAX >> BITS) != 0) begin : g_bad_max
      $fatal(1, "mod_up_down_counter: MAX must lie in 1..2^BITS-1");
    end
  endgenerate

  logic [BITS-1:0] s_eff;
  logic [BITS-1:0] d_eff;

  // Clamp step and load value to MAX; a full-range MAX needs no clamp.
  generate
    if (FULL) begin : g_no_clip
      assign s_eff = step;
      assign d_eff = d;
    end else begin : g_clip
      assign s_eff = (step > MAX_B) ? MAX_B : step;
      assign d_eff = (d > MAX_B) ? MAX_B : d;
    end
  endgenerate

  logic [W-1:0]    sum;
  logic [BITS-1:0] q_next;
  logic            tc_next;
  logic            ovf_next;
  logic            boundary;

  // Next-state: load, then enabled count with boundary detection.
  always_comb begin
    sum      = {1'b0, Q} + {1'b0, s_eff};
    q_next   = Q;
    boundary = 1'b0;
    if (load) begin
      q_next = d_eff;
    end else if (enable) begin
      if (up) begin
        if (sum > MAX_W) begin
          boundary = 1'b1;
          q_next   = SATURATE ? MAX_B : BITS'(sum - MOD_W);
        end else begin
          q_next = BITS'(sum);
        end
      end else begin
        if (s_eff <= Q) begin
          q_next = Q - s_eff;
        end else begin
          boundary = 1'b1;
          q_next   = SATURATE ? '0 : BITS'({1'b0, Q} + MOD_W - {1'b0, s_eff});
        end
      end
    end
    tc_next  = boundary;
    ovf_next = boundary ? 1'b1 : (clr_flags ? 1'b0 : ovf);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Q   <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      Q   <= q_next;
      tc  <= tc_next;
      ovf <= ovf_next;
    end
  end

  assign at_max = (Q == MAX_B);
  assign at_min = (Q == '0);

endmodule

// File: tb/tb_mod_up_down_counter.sv
// Bench for mod_up_down_counter: three configurations share stimulus and are
// checked every cycle against an integer reference model plus directed values.
module tb_mod_up_down_counter;

  logic       clk = 1'b0;
  logic       reset, enable, up, load, clr_flags;
  logic [3:0] step, d;
  logic [3:0] q_o [3];
  logic       amax_o [3];
  logic       amin_o [3];
  logic       tc_o [3];
  logic       ovf_o [3];

  localparam int MXV [3] = '{9, 9, 15};
  localparam int STV [3] = '{0, 1, 0};

  int mq [3];
  int mtc [3];
  int movf [3];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  mod_up_down_counter #(.BITS(4), .MAX(9), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .step(step),
    .load(load), .d(d), .clr_flags(clr_flags), .Q(q_o[0]),
    .at_max(amax_o[0]), .at_min(amin_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]));

  mod_up_down_counter #(.BITS(4), .MAX(9), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .step(step),
    .load(load), .d(d), .clr_flags(clr_flags), .Q(q_o[1]),
    .at_max(amax_o[1]), .at_min(amin_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]));

  mod_up_down_counter dut_full (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .step(step),
    .load(load), .d(d), .clr_flags(clr_flags), .Q(q_o[2]),
    .at_max(amax_o[2]), .at_min(amin_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2]));

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Reference: the counter as an integer on the ring/segment 0..max.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int s, t, ev;
      ev = 0;
      if (reset) begin
        mq[i] = 0; mtc[i] = 0; movf[i] = 0;
      end else begin
        if (load) begin
          mq[i] = (int'(d) > MXV[i]) ? MXV[i] : int'(d);
        end else if (enable) begin
          s = (int'(step) > MXV[i]) ? MXV[i] : int'(step);
          t = up ? mq[i] + s : mq[i] - s;
          if (t > MXV[i]) begin
            ev = 1;
            mq[i] = STV[i] ? MXV[i] : t - (MXV[i] + 1);
          end else if (t < 0) begin
            ev = 1;
            mq[i] = STV[i] ? 0 : t + (MXV[i] + 1);
          end else begin
            mq[i] = t;
          end
        end
        mtc[i] = ev;
        if (ev != 0) movf[i] = 1;
        else if (clr_flags) movf[i] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("q%0d", i), int'(q_o[i]), mq[i]);
      check($sformatf("at_max%0d", i), int'(amax_o[i]), int'(mq[i] == MXV[i]));
      check($sformatf("at_min%0d", i), int'(amin_o[i]), int'(mq[i] == 0));
      check($sformatf("tc%0d", i), int'(tc_o[i]), mtc[i]);
      check($sformatf("ovf%0d", i), int'(ovf_o[i]), movf[i]);
    end
  endtask

  task automatic set_in(input logic r, input logic e, input logic u,
                        input int st, input logic l, input int dv, input logic c);
    reset = r; enable = e; up = u; step = 4'(st); load = l; d = 4'(dv); clr_flags = c;
  endtask

  initial begin
    int seq2 [5];
    int tc2 [5];
    int seq3 [7];
    int tc3 [7];
    seq2 = '{1, 8, 5, 2, 9};
    tc2  = '{0, 1, 0, 0, 1};
    seq3 = '{4, 8, 9, 9, 5, 1, 0};
    tc3  = '{0, 0, 1, 1, 0, 0, 1};
    foreach (mq[i]) begin mq[i] = 0; mtc[i] = 0; movf[i] = 0; end

    // Reset state and count up by 1 through the wrap.
    set_in(1, 0, 1, 1, 0, 0, 0);
    tick();
    check("rst_q", int'(q_o[0]), 0);
    check("rst_ovf", int'(ovf_o[0]), 0);
    set_in(0, 1, 1, 1, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("t1_q", int'(q_o[0]), k % 10);
      check("t1_tc", int'(tc_o[0]), int'(k == 10));
      check("t1_at_max", int'(amax_o[0]), int'(k == 9));
    end
    check("t1_ovf", int'(ovf_o[0]), 1);

    // Load 4 then count down by 3 with wrap.
    set_in(0, 0, 0, 3, 1, 4, 0);
    tick();
    check("t2_load", int'(q_o[0]), 4);
    set_in(0, 1, 0, 3, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t2_q", int'(q_o[0]), seq2[k]);
      check("t2_tc", int'(tc_o[0]), tc2[k]);
    end

    // Saturating instance: up by 4 to the clamp, then down to 0.
    set_in(1, 0, 1, 4, 0, 0, 0);
    tick();
    set_in(0, 1, 1, 4, 0, 0, 0);
    for (int k = 0; k < 7; k++) begin
      if (k == 4) up = 1'b0;
      tick();
      check("t3_q", int'(q_o[1]), seq3[k]);
      check("t3_tc", int'(tc_o[1]), tc3[k]);
    end

    // Load beyond MAX wins over enable; oversize step wraps.
    set_in(0, 1, 1, 1, 1, 15, 0);
    tick();
    check("t4_load", int'(q_o[0]), 9);
    check("t4_tc", int'(tc_o[0]), 0);
    check("t4_full_load", int'(q_o[2]), 15);
    set_in(0, 1, 1, 12, 0, 0, 0);
    tick();
    check("t4_q", int'(q_o[0]), 8);
    check("t4_tc2", int'(tc_o[0]), 1);

    // Reset overrides load and clr mid-count; hold while disabled.
    set_in(0, 0, 1, 1, 1, 6, 0);
    tick();
    check("t5_q6", int'(q_o[0]), 6);
    set_in(1, 1, 1, 1, 1, 6, 1);
    tick();
    check("t5_q", int'(q_o[0]), 0);
    check("t5_tc", int'(tc_o[0]), 0);
    check("t5_ovf", int'(ovf_o[0]), 0);
    set_in(0, 0, 1, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t5_hold", int'(q_o[0]), 0);
    end

    // Set beats clear on a wrap edge; a later quiet clear wins.
    set_in(0, 0, 1, 1, 1, 9, 0);
    tick();
    set_in(0, 1, 1, 1, 0, 0, 1);
    tick();
    check("t6_q", int'(q_o[0]), 0);
    check("t6_ovf_set", int'(ovf_o[0]), 1);
    set_in(0, 0, 1, 1, 0, 0, 1);
    tick();
    check("t6_ovf_clr", int'(ovf_o[0]), 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      set_in(logic'($urandom_range(0, 99) < 2), logic'($urandom_range(0, 99) < 80),
             logic'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
             logic'($urandom_range(0, 99) < 10), int'($urandom_range(0, 15)),
             logic'($urandom_range(0, 99) < 10));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_up_down_counter.md
Name: mod_up_down_counter

Overview:
Parametrised successor to the basic up/down counter. Counts up or down over a programmable range 0..MAX with a per-cycle step size, parallel load, and a selectable wrap or saturate mode. Also provides boundary flags, a registered terminal-count pulse and a sticky overflow flag. Intended as the general-purpose counter for timers, address generators and BCD/modulo-N stages.

Parameters:
BITS, 4, width of count, load and step buses
MAX, 15, highest count value; legal range 1 <= MAX <= 2^BITS-1
SATURATE, 0, 0 = modulo wrap at boundaries, 1 = clamp at 0/MAX

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
enable  input  1  count enable; when low, count holds
up  input  1  direction: 1 = count up, 0 = count down
step  input  BITS  increment/decrement amount; values > MAX are treated as MAX
load  input  1  synchronous parallel load
d  input  BITS  load value; values > MAX are loaded as MAX
clr_flags  input  1  clears sticky ovf
Q  output  BITS  registered count
at_max  output  1  combinational, Q == MAX
at_min  output  1  combinational, Q == 0
tc  output  1  registered one-cycle terminal-count pulse
ovf  output  1  registered sticky boundary-crossing flag

Behaviour:
- Reset (sampled at the clk edge with reset=1): Q=0, tc=0, ovf=0. Reset overrides everything else, including mid-count, load and clr_flags.
- Priority at each edge: reset > load > enable count > hold.
- Load: Q <= min(d, MAX); tc <= 0; ovf is unchanged. Load wins over enable in the same cycle.
- Effective step s = min(step, MAX). Arithmetic is done at BITS+1 width so there is no intermediate overflow.
- s = 0 with enable=1: Q holds, no boundary event.
- Count up (enable=1, up=1):
  - If Q+s <= MAX: Q <= Q+s, no event.
  - Else, boundary event. SATURATE=0: Q <= Q+s-(MAX+1). SATURATE=1: Q <= MAX.
- Count down (enable=1, up=0):
  - If s <= Q: Q <= Q-s, no event.
  - Else, boundary event. SATURATE=0: Q <= Q+(MAX+1)-s. SATURATE=1: Q <= 0.
- In saturate mode, a boundary event occurs whenever Q is already at the limit and s > 0.
- tc: asserted for exactly the cycle after an edge at which a boundary event occurred, so it is coincident with the new Q. Deasserted after any edge with no event, including hold, load or disabled cycles. Back-to-back events give tc high for consecutive cycles.
- ovf: set by any boundary event. Cleared by clr_flags only when no event occurs on the same edge; set wins over clear.
- Direction or step changes take effect on the next enabled edge. No pipeline; latency from inputs to Q is 1 clock.
- Q never exceeds MAX under any input sequence.
- Elaboration-time check: MAX outside 1..2^BITS-1 is a fatal error.

Test Plan:
1. BITS=4, MAX=9, SATURATE=0, step=1, up=1, from reset -> Q counts 0..9, then 0; tc high only in the cycle Q=0 after 9; ovf=1; at_max high while Q=9.
2. Same config, up=0, step=3, load d=4 then enable -> Q sequence 4, 1, 8 (tc=1, wrap), 5, 2, 9 (tc=1).
3. SATURATE=1, MAX=9, step=4, up=1 from Q=0 -> 4, 8, 9 (tc=1), 9 (tc=1); then up=0 -> 5, 1, 0 (tc=1).
4. load=1 with d=15, enable=1, MAX=9 -> Q=9 next cycle, tc=0; step=12 up wrap from 9 -> Q=9+9-10=8.
5. Drive reset=1 mid-count at Q=6 with load=1 and clr_flags=1 -> next edge Q=0, tc=0, ovf=0. enable=0 for 5 cycles -> Q holds at 0.
6. clr_flags on the same edge as a wrap event -> ovf stays 1. clr_flags on a later quiet edge -> ovf=0.
